// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and the stopwatch:
// FSM state encodings and the default prescaler ratio.
package countdown_timer_pkg;

   // Default clk cycles per count decrement
   localparam int DIV_DEFAULT = 4;

   // Width of the prescaler counter (covers DIV up to 65535)
   localparam int PRESC_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_ALARM = 2'b11
   } state_t;

endpackage

// File: rtl/countdown_timer_btn_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// rising-edge detector producing a one-cycle press pulse.
module btn_edge (
   input  logic clk,
   input  logic rst,      // synchronous, active-low
   input  logic i_btn,
   output logic o_press
);

   logic r_s1;
   logic r_s2;

   // Synchronize the button level; clearing both flops on reset makes a
   // button held through reset release count as exactly one press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
      end
   end

   assign o_press = r_s1 & ~r_s2;

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a preset in IDLE, decrements once every DIV clk
// cycles in RUN, can be paused/resumed/cleared, and raises an alarm at 0.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,      // synchronous, active-low
   input  logic       sw1,      // start / resume
   input  logic       sw2,      // pause
   input  logic       sw3,      // clear / acknowledge
   input  logic [7:0] set_val,
   output logic [7:0] dsp,
   output logic       alarm,
   output logic       busy
);

   localparam logic [PRESC_W-1:0] LP_PRESC_MAX = PRESC_W'(DIV - 1);

   logic [2:0]         w_sw;
   logic [2:0]         w_press;
   logic               w_press1;
   logic               w_press2;
   logic               w_press3;
   logic               w_tick;

   state_t             r_state;
   state_t             w_state_next;
   logic [7:0]         r_cnt;
   logic [7:0]         w_cnt_next;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] w_presc_next;

   logic [7:0]         r_dsp;
   logic               r_alarm;
   logic               r_busy;

   assign w_sw = {sw3, sw2, sw1};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_edge u_btn_edge (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (w_sw[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   assign w_press1 = w_press[0];
   assign w_press2 = w_press[1];
   assign w_press3 = w_press[2];
   assign w_tick   = (r_presc == LP_PRESC_MAX);

   // Next-state, count and prescaler decode; press priority is 3 > 2 > 1
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_presc_next = r_presc;
      case (r_state)
         ST_IDLE: begin
            // The preset tracks set_val only while idle
            w_cnt_next   = set_val;
            w_presc_next = '0;
            if (!w_press3 && !w_press2 && w_press1 && (set_val != 8'd0)) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_press3) begin
               w_state_next = ST_IDLE;
            end else if (w_press2) begin
               w_state_next = ST_PAUSE;
            end else if (!w_press1) begin
               // A cycle carrying any press swallows its tick entirely
               if (w_tick) begin
                  w_presc_next = '0;
                  if (r_cnt != 8'd0) begin
                     w_cnt_next = r_cnt - 8'd1;
                  end
                  if (r_cnt <= 8'd1) begin
                     w_state_next = ST_ALARM;
                  end
               end else begin
                  w_presc_next = r_presc + PRESC_W'(1);
               end
            end
         end
         ST_PAUSE: begin
            if (w_press3) begin
               w_state_next = ST_IDLE;
            end else if (!w_press2 && w_press1) begin
               w_state_next = ST_RUN;
            end
         end
         ST_ALARM: begin
            w_cnt_next = 8'd0;
            if (w_press3) begin
               w_state_next = ST_IDLE;
            end else if (!w_press2 && w_press1) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State, count and prescaler registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_presc <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_presc <= w_presc_next;
      end
   end

   // Registered outputs, one cycle behind the count and state
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dsp   <= 8'd0;
         r_alarm <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_dsp   <= r_cnt;
         r_alarm <= (r_state == ST_ALARM);
         r_busy  <= (r_state == ST_RUN) || (r_state == ST_PAUSE);
      end
   end

   assign dsp   = r_dsp;
   assign alarm = r_alarm;
   assign busy  = r_busy;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by
// random button/preset/reset activity, all compared against a behavioural
// model that derives the remaining count from accumulated run time.
module tb_countdown_timer;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sw1 = 1'b0;
   logic       sw2 = 1'b0;
   logic       sw3 = 1'b0;
   logic [7:0] set_val = 8'd0;
   logic [7:0] dsp;
   logic       alarm;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Behavioural model: mode 0 idle, 1 run, 2 pause, 3 alarm
   int         m_mode   = 0;
   int         m_preset = 0;
   int         m_run    = 0;   // counting cycles spent in RUN since start
   int         m_cnt    = 0;
   logic [2:0] m_q1     = 3'b000;  // button levels seen at previous edge
   logic [2:0] m_q2     = 3'b000;  // button levels seen two edges ago
   logic [7:0] exp_dsp  = 8'd0;
   logic       exp_alarm = 1'b0;
   logic       exp_busy  = 1'b0;

   countdown_timer #(.DIV(DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw1     (sw1),
      .sw2     (sw2),
      .sw3     (sw3),
      .set_val (set_val),
      .dsp     (dsp),
      .alarm   (alarm),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
      n_cmp++;
      assert (got === expv) else begin
         n_err++;
         $error("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, expv);
      end
   endtask

   // Advance the model by one clk edge using the inputs present at that edge
   task automatic model_edge();
      logic [2:0] pr;
      if (!rst) begin
         exp_dsp   = 8'd0;
         exp_alarm = 1'b0;
         exp_busy  = 1'b0;
         m_mode = 0; m_cnt = 0; m_run = 0; m_preset = 0;
         m_q1 = 3'b000; m_q2 = 3'b000;
      end else begin
         exp_dsp   = 8'(m_cnt);
         exp_alarm = (m_mode == 3);
         exp_busy  = (m_mode == 1) || (m_mode == 2);
         pr = m_q1 & ~m_q2;
         case (m_mode)
            0: begin
               if (!pr[2] && !pr[1] && pr[0] && set_val != 8'd0) begin
                  m_mode = 1; m_preset = int'(set_val); m_run = 0;
               end
               m_cnt = int'(set_val);
            end
            1: begin
               if (pr[2]) m_mode = 0;
               else if (pr[1]) m_mode = 2;
               else if (!pr[0]) begin
                  m_run++;
                  if (m_run / DIV >= m_preset) m_mode = 3;
               end
               m_cnt = m_preset - m_run / DIV;
            end
            2: begin
               if (pr[2]) m_mode = 0;
               else if (!pr[1] && pr[0]) m_mode = 1;
            end
            default: begin
               if (pr[2] || (!pr[1] && pr[0])) m_mode = 0;
               m_cnt = 0;
            end
         endcase
         m_q2 = m_q1;
         m_q1 = {sw3, sw2, sw1};
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         cyc++;
         chk("dsp", dsp, exp_dsp);
         chk("alarm", {7'd0, alarm}, {7'd0, exp_alarm});
         chk("busy", {7'd0, busy}, {7'd0, exp_busy});
      end
   endtask

   task automatic pulse_sw3();
      sw3 = 1'b1; cycles(1); sw3 = 1'b0; cycles(3);
   endtask

   initial begin
      // Reset with every button held
      rst = 1'b0; sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1; set_val = 8'd3;
      cycles(2);
      chk("rst_dsp", dsp, 8'd0);
      chk("rst_alarm", {7'd0, alarm}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      $display("step reset: dsp=%0d alarm=%0d busy=%0d", dsp, alarm, busy);

      // Release with sw1 still held: one press starts the run at edge E
      rst = 1'b1; sw2 = 1'b0; sw3 = 1'b0;
      cycles(2);           // edges r1, E
      cycles(3);           // E+1..E+3, sw1 still held
      sw1 = 1'b0;
      cycles(9);           // E+4..E+12
      chk("run_dsp_e12", dsp, 8'd1);
      chk("run_alarm_e12", {7'd0, alarm}, 8'd0);
      chk("run_busy_e12", {7'd0, busy}, 8'd1);
      cycles(1);           // E+13
      chk("run_dsp_e13", dsp, 8'd0);
      chk("run_alarm_e13", {7'd0, alarm}, 8'd1);
      chk("run_busy_e13", {7'd0, busy}, 8'd0);
      $display("step full_run: dsp=%0d alarm=%0d busy=%0d", dsp, alarm, busy);

      // Acknowledge by holding sw1: single return to IDLE, no restart
      sw1 = 1'b1; cycles(10); sw1 = 1'b0; cycles(3);
      chk("ack_alarm", {7'd0, alarm}, 8'd0);
      chk("ack_busy", {7'd0, busy}, 8'd0);
      chk("ack_dsp", dsp, 8'd3);
      $display("step ack: dsp=%0d alarm=%0d busy=%0d", dsp, alarm, busy);

      // Pause two prescaler cycles after cnt reaches 4, then resume
      set_val = 8'd5;
      sw1 = 1'b1; cycles(1); sw1 = 1'b0;
      cycles(6);
      sw2 = 1'b1; cycles(1); sw2 = 1'b0;
      cycles(22);
      chk("pause_dsp", dsp, 8'd4);
      chk("pause_busy", {7'd0, busy}, 8'd1);
      sw1 = 1'b1; cycles(1); sw1 = 1'b0;
      cycles(3);           // R, R+1, R+2 (decrement lands on R+2)
      chk("resume_dsp_r2", dsp, 8'd4);
      cycles(1);
      chk("resume_dsp_r3", dsp, 8'd3);
      $display("step pause_resume: dsp=%0d busy=%0d", dsp, busy);
      pulse_sw3();

      // Zero preset never leaves IDLE
      set_val = 8'd0;
      sw1 = 1'b1; cycles(1); sw1 = 1'b0;
      cycles(6);
      chk("zero_busy", {7'd0, busy}, 8'd0);
      chk("zero_dsp", dsp, 8'd0);
      $display("step zero_preset: dsp=%0d busy=%0d", dsp, busy);

      // sw2 and sw3 together in RUN go straight to IDLE
      set_val = 8'd7;
      sw1 = 1'b1; cycles(1); sw1 = 1'b0;
      cycles(3);
      sw2 = 1'b1; sw3 = 1'b1; cycles(1); sw2 = 1'b0; sw3 = 1'b0;
      cycles(2);
      chk("simul_busy", {7'd0, busy}, 8'd0);
      cycles(2);
      chk("simul_dsp", dsp, 8'd7);
      $display("step simultaneous: dsp=%0d busy=%0d", dsp, busy);

      // A press landing on a tick cycle discards that tick
      sw1 = 1'b1; cycles(1); sw1 = 1'b0;
      cycles(3);
      sw1 = 1'b1; cycles(1); sw1 = 1'b0;
      cycles(2);           // E+4 (held), E+5 (tick)
      chk("tickpress_dsp_e5", dsp, 8'd7);
      cycles(1);
      chk("tickpress_dsp_e6", dsp, 8'd6);
      $display("step press_on_tick: dsp=%0d", dsp);
      pulse_sw3();

      // Random buttons, presets and occasional resets
      for (int r = 0; r < 4000; r++) begin
         if ($urandom_range(0, 11) == 0) sw1 = ~sw1;
         if ($urandom_range(0, 29) == 0) sw2 = ~sw2;
         if ($urandom_range(0, 49) == 0) sw3 = ~sw3;
         if ($urandom_range(0, 19) == 0) set_val = 8'($urandom_range(0, 6));
         rst = ($urandom_range(0, 599) != 0);
         cycles(1);
         if (r % 1000 == 999)
            $display("step random %0d: dsp=%0d alarm=%0d busy=%0d", r + 1, dsp, alarm, busy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: DIV, default 4, meaning prescaler ratio in clk cycles per count decrement, legal range 2..65535.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: sw1  input  1  start/resume button, level, asynchronous to clk.
REQ-005 Port: sw2  input  1  pause button, level, asynchronous to clk.
REQ-006 Port: sw3  input  1  clear/acknowledge button, level, asynchronous to clk.
REQ-007 Port: set_val  input  8  preset count in unsigned binary, quasi-static.
REQ-008 Port: dsp  output  8  current remaining count, registered.
REQ-009 Port: alarm  output  1  high while in ALARM, registered.
REQ-010 Port: busy  output  1  high while in RUN or PAUSE, registered.

Function
REQ-011 Each swN SHALL pass two flip-flops (s1, s2); press_N = s1 & ~s2, a one-cycle pulse per rising edge of the button.
REQ-012 A button high at clk edge k (low at k-1) SHALL change state at edge k+1; holding a button SHALL NOT generate further presses.
REQ-013 FSM states SHALL be IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, ALARM=2'b11; undefined encodings not reachable; default branch goes to IDLE.
REQ-014 IDLE: cnt SHALL load set_val every cycle; press_1 with set_val != 0 -> RUN with prescaler cleared to 0; press_1 with set_val == 0 -> stay IDLE.
REQ-015 RUN: prescaler SHALL increment each cycle; when prescaler == DIV-1 it wraps to 0 and cnt decrements by 1 (tick).
REQ-016 RUN: tick with cnt == 1 SHALL set cnt to 0 and enter ALARM on the same edge.
REQ-017 RUN: press_3 -> IDLE; else press_2 -> PAUSE; in a cycle with any press the tick SHALL be discarded (cnt and prescaler hold).
REQ-018 PAUSE: cnt and prescaler SHALL hold; press_3 -> IDLE; else press_1 -> RUN, prescaler resumes from held value; press_2 ignored.
REQ-019 ALARM: cnt SHALL hold 0; press_3 or press_1 -> IDLE; press_2 ignored.
REQ-020 Simultaneous presses: priority press_3 > press_2 > press_1 in every state.
REQ-021 cnt SHALL never wrap below 0; decrement only occurs from cnt >= 1 in RUN.
REQ-022 dsp SHALL equal cnt registered one cycle late; alarm and busy SHALL be registered decodes of the state, also one cycle late.
REQ-023 set_val changes outside IDLE SHALL have no effect.

Reset
REQ-024 rst == 0 at a clk edge SHALL force state IDLE, cnt 0, prescaler 0, s1/s2 of all buttons 0, dsp 0, alarm 0, busy 0.
REQ-025 Reset mid-RUN or mid-ALARM SHALL abandon the count with no residual press; a button held through reset release SHALL register as one press.

Structure
REQ-026 State encodings and the default DIV value SHALL live in a shared include file used by both this block and the stopwatch.
REQ-027 One sub-module, btn_edge (two-flop synchronizer plus rising-edge pulse), SHALL be instantiated three times.
REQ-028 FSM next-state logic combinational; state, cnt, prescaler and outputs in clocked processes.

Verification
REQ-029 Reset: rst low 2 cycles with all buttons high -> dsp=0, alarm=0, busy=0; after release exactly one press_1 seen.
REQ-030 Full run: DIV=4, set_val=3, sw1 pulse -> RUN on entry edge E, cnt 2/1/0 at E+4/E+8/E+12, ALARM at E+12, alarm=1 from E+13.
REQ-031 Pause/resume: set_val=5, pause after cnt=4 plus 2 prescaler cycles, hold 20 cycles -> dsp stays 4; resume -> next decrement 2 cycles after resume edge.
REQ-032 Zero preset: set_val=0, sw1 pulse -> state stays IDLE, busy stays 0.
REQ-033 Simultaneous: in RUN assert sw2 and sw3 together -> IDLE, dsp reloads set_val, no PAUSE visited; press coinciding with tick -> no decrement.
REQ-034 Acknowledge: in ALARM hold sw1 10 cycles -> single transition to IDLE, no immediate restart.
